// File: rtl/fd_stage_reg_pkg.sv
// Shared constants for the fetch/decode boundary: exception codes, the nop
// encoding, default reset/exception-entry PCs, the text segment bounds used
// by fetch, and the update-priority selector used by the stage register.
package fd_stage_reg_pkg;

  localparam logic [4:0]  EXC_NONE          = 5'd0;
  localparam logic [4:0]  EXC_ADEL          = 5'd4;
  localparam logic [31:0] NOP               = 32'h0000_0000;
  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] TEXT_BASE         = 32'h0000_3000;
  localparam logic [31:0] TEXT_LIMIT        = 32'h0000_6FFF;
  localparam logic [31:0] CNT_MAX           = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    UPD_RESET,
    UPD_REQ,
    UPD_HOLD,
    UPD_FLUSH,
    UPD_LOAD
  } upd_e;

  // reset > req > stall > flush > load; a flush seen during a stall is
  // dropped because the hazard unit re-asserts it once the stall clears.
  function automatic upd_e sel_update(input logic reset, input logic req,
                                      input logic stall, input logic flush);
    if (reset)      return UPD_RESET;
    else if (req)   return UPD_REQ;
    else if (stall) return UPD_HOLD;
    else if (flush) return UPD_FLUSH;
    else            return UPD_LOAD;
  endfunction

endpackage

// File: rtl/fd_perf_cnt.sv
// Pair of 32-bit saturating event counters for the fetch/decode register:
// stall cycles and bubble insertions.
module fd_perf_cnt
  import fd_stage_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_stall,
  input  logic        inc_bubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (inc_stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 32'd1;
      if (inc_bubble && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fd_stage_reg.sv
// Fetch-to-decode pipeline register. Captures PC, instruction, fetch address
// error and delay-slot flag, and applies the reset/req/stall/flush rules.
// Optional feature: define FD_PERF_EN to add stall and bubble counters.
module fd_stage_reg
  import fd_stage_reg_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_ex_adel,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd,
  output logic        d_valid
`ifdef FD_PERF_EN
  ,
  output logic [31:0] d_stall_cnt,
  output logic [31:0] d_bubble_cnt
`endif
);

  upd_e upd;

  // Resolve which of the competing update sources owns this edge.
  always_comb begin
    upd = sel_update(reset, req, stall, flush);
  end

  // Stage register. A faulting fetch still enters decode as a valid slot,
  // with its PC and bd kept so CP0 can form the right EPC.
  always_ff @(posedge clk) begin
    case (upd)
      UPD_RESET: begin
        d_pc      <= RESET_PC;
        d_instr   <= NOP;
        d_exccode <= EXC_NONE;
        d_bd      <= 1'b0;
        d_valid   <= 1'b0;
      end
      UPD_REQ: begin
        d_pc      <= EXC_ENTRY;
        d_instr   <= NOP;
        d_exccode <= EXC_NONE;
        d_bd      <= 1'b0;
        d_valid   <= 1'b0;
      end
      UPD_FLUSH: begin
        d_pc      <= f_pc;
        d_instr   <= NOP;
        d_exccode <= EXC_NONE;
        d_bd      <= 1'b0;
        d_valid   <= 1'b0;
      end
      UPD_LOAD: begin
        d_pc      <= f_pc;
        d_instr   <= f_ex_adel ? NOP : f_instr;
        d_exccode <= f_ex_adel ? EXC_ADEL : EXC_NONE;
        d_bd      <= f_bd;
        d_valid   <= 1'b1;
      end
      default: begin
        d_pc      <= d_pc;
        d_instr   <= d_instr;
        d_exccode <= d_exccode;
        d_bd      <= d_bd;
        d_valid   <= d_valid;
      end
    endcase
  end

`ifdef FD_PERF_EN
  logic inc_stall;
  logic inc_bubble;

  assign inc_stall  = (upd == UPD_HOLD);
  assign inc_bubble = (upd == UPD_REQ) || (upd == UPD_FLUSH);

  fd_perf_cnt u_perf_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc_stall  (inc_stall),
    .inc_bubble (inc_bubble),
    .stall_cnt  (d_stall_cnt),
    .bubble_cnt (d_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_fd_stage_reg.sv
// Bench for fd_stage_reg: directed vector table followed by random stimulus
// checked against a behavioural model. Counter checks exist when FD_PERF_EN
// is defined.
module tb_fd_stage_reg;

  logic        clk = 1'b0;
  logic        reset, req, stall, flush, f_ex_adel, f_bd;
  logic [31:0] f_pc, f_instr;
  logic [31:0] d_pc, d_instr;
  logic [4:0]  d_exccode;
  logic        d_bd, d_valid;
`ifdef FD_PERF_EN
  logic [31:0] d_stall_cnt, d_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fd_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .stall     (stall),
    .flush     (flush),
    .f_pc      (f_pc),
    .f_instr   (f_instr),
    .f_ex_adel (f_ex_adel),
    .f_bd      (f_bd),
    .d_pc      (d_pc),
    .d_instr   (d_instr),
    .d_exccode (d_exccode),
    .d_bd      (d_bd),
    .d_valid   (d_valid)
`ifdef FD_PERF_EN
    ,
    .d_stall_cnt  (d_stall_cnt),
    .d_bubble_cnt (d_bubble_cnt)
`endif
  );

  typedef struct {
    logic        rst, rq, st, fl, adel, bd;
    logic [31:0] pc, instr;
    logic [31:0] e_pc, e_instr;
    logic [4:0]  e_exc;
    logic        e_bd, e_valid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_scnt, m_bcnt;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;

  function automatic vec_t mk(logic rst, logic rq, logic st, logic fl,
                              logic adel, logic bd, logic [31:0] pc,
                              logic [31:0] instr, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic [4:0] e_exc,
                              logic e_bd, logic e_valid);
    vec_t v;
    v.rst = rst; v.rq = rq; v.st = st; v.fl = fl; v.adel = adel; v.bd = bd;
    v.pc = pc; v.instr = instr; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_exc = e_exc; v.e_bd = e_bd; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Model: apply the priority rules to the inputs present at this edge.
  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0000_3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_scnt = 0; m_bcnt = 0;
    end else if (req) begin
      m_pc = 32'h0000_4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_bcnt = sat_inc(m_bcnt);
    end else if (stall) begin
      m_scnt = sat_inc(m_scnt);
    end else if (flush) begin
      m_pc = f_pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_bcnt = sat_inc(m_bcnt);
    end else begin
      m_pc = f_pc;
      m_instr = f_ex_adel ? 32'h0 : f_instr;
      m_exc = f_ex_adel ? 5'd4 : 5'd0;
      m_bd = f_bd;
      m_valid = 1'b1;
    end
  endtask

  task automatic drive(logic rst, logic rq, logic st, logic fl, logic adel,
                       logic bd, logic [31:0] pc, logic [31:0] instr);
    reset = rst; req = rq; stall = st; flush = fl;
    f_ex_adel = adel; f_bd = bd; f_pc = pc; f_instr = instr;
  endtask

  task automatic edge_and_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef FD_PERF_EN
    check({tag, ".stall_cnt"}, d_stall_cnt, m_scnt);
    check({tag, ".bubble_cnt"}, d_bubble_cnt, m_bcnt);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    m_scnt = 0; m_bcnt = 0;

    //          rst rq st fl ad bd  f_pc          f_instr        e_pc          e_instr        exc  bd valid
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3000, 32'h3C01_1234, 32'h0000_3000, 32'h3C01_1234, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3004, 32'h2401_0001, 32'h0000_3004, 32'h2401_0001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h0000_3008, 32'h2402_0002, 32'h0000_3004, 32'h2401_0001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h0000_3008, 32'h2402_0002, 32'h0000_3004, 32'h2401_0001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h0000_3008, 32'h2402_0002, 32'h0000_3004, 32'h2401_0001, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_3008, 32'h2402_0002, 32'h0000_3008, 32'h2402_0002, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0000_3002, 32'hFFFF_FFFF, 32'h0000_3002, 32'h0,         4, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0000_3010, 32'h1234_5678, 32'h0000_4180, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h0000_3010, 32'h1234_5678, 32'h0000_3010, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_300C, 32'h1111_2222, 32'h0000_300C, 32'h1111_2222, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0000_3020, 32'h3333_4444, 32'h0000_300C, 32'h1111_2222, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0000_3024, 32'h5555_6666, 32'h0000_3024, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3010, 32'hAAAA_5555, 32'h0000_3010, 32'hAAAA_5555, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 32'h0000_3040, 32'h7777_8888, 32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3030, 32'h1234_5678, 32'h0000_3030, 32'h1234_5678, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 32'h0000_3034, 32'h9999_0000, 32'h0000_4180, 32'h0,         0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h0000_3038, 32'h9999_0000, 32'h0000_3000, 32'h0,         0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rq, vecs[i].st, vecs[i].fl, vecs[i].adel,
            vecs[i].bd, vecs[i].pc, vecs[i].instr);
      edge_and_model();
      check($sformatf("tbl%0d.d_pc", i), d_pc, vecs[i].e_pc);
      check($sformatf("tbl%0d.d_instr", i), d_instr, vecs[i].e_instr);
      check($sformatf("tbl%0d.d_exccode", i), {27'd0, d_exccode}, {27'd0, vecs[i].e_exc});
      check($sformatf("tbl%0d.d_bd", i), {31'd0, d_bd}, {31'd0, vecs[i].e_bd});
      check($sformatf("tbl%0d.d_valid", i), {31'd0, d_valid}, {31'd0, vecs[i].e_valid});
      check_counters($sformatf("tbl%0d", i));
    end

    // Long stall run with changing fetch inputs, then release.
    drive(0, 0, 0, 0, 0, 0, 32'h0000_3100, 32'h0BAD_F00D);
    edge_and_model();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, k[0], k[1], k[2], 32'h0000_3200 + k * 4, $urandom);
      edge_and_model();
    end
    check("longstall.d_pc", d_pc, 32'h0000_3100);
    check("longstall.d_instr", d_instr, 32'h0BAD_F00D);
    check_counters("longstall");
    drive(0, 0, 0, 0, 0, 0, 32'h0000_3300, 32'hCAFE_0001);
    edge_and_model();
    check("release.d_pc", d_pc, 32'h0000_3300);
    check("release.d_instr", d_instr, 32'hCAFE_0001);

    // Random stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            32'h0000_3000 + ($urandom & 32'h0000_3FFF), $urandom);
      edge_and_model();
      check("rnd.d_pc", d_pc, m_pc);
      check("rnd.d_instr", d_instr, m_instr);
      check("rnd.d_exccode", {27'd0, d_exccode}, {27'd0, m_exc});
      check("rnd.d_bd", {31'd0, d_bd}, {31'd0, m_bd});
      check("rnd.d_valid", {31'd0, d_valid}, {31'd0, m_valid});
      check_counters("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fd_stage_reg.md
# fd_stage_reg

Fetch-to-decode pipeline register of the five-stage MIPS core. It captures the fetch stage's PC, instruction word, fetch-address exception and delay-slot flag on each clock edge and presents them to decode. It also implements the stall, eret-squash and exception-entry rules that the fetch stage relies on. It sits directly downstream of the fetch PC register and the instruction memory, and upstream of the decoder and hazard unit.

## Interface
Parameters:
- EXC_ENTRY, 32'h0000_4180, PC loaded into decode on exception/interrupt entry
- RESET_PC, 32'h0000_3000, decode PC after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt taken this cycle (from CP0); highest non-reset priority
- stall  in  1  hazard-unit stall; hold all state
- flush  in  1  eret in decode; squash the fetched instruction
- f_pc  in  32  fetch PC
- f_instr  in  32  instruction word at f_pc
- f_ex_adel  in  1  fetch address error (misaligned or outside 0x3000–0x6FFF)
- f_bd  in  1  fetched instruction is in a branch delay slot
- d_pc  out  32  decode PC
- d_instr  out  32  decode instruction (0 = nop)
- d_exccode  out  5  pending exception code (0 = none, 4 = AdEL)
- d_bd  out  1  decode delay-slot flag
- d_valid  out  1  decode holds a real (non-bubble) instruction
- d_stall_cnt, d_bubble_cnt  out  32  present only with FD_PERF_EN

## Operation
Update priority at each posedge, highest first: reset > req > stall > flush > load.
- **reset:** d_pc=RESET_PC, d_instr=0, d_exccode=0, d_bd=0, d_valid=0.
- **req:** bubble with d_pc=EXC_ENTRY, d_instr=0, d_exccode=0, d_bd=0, d_valid=0. Overrides a simultaneous stall.
- **stall (no req):** every register holds. flush is ignored while stall=1; the hazard unit re-asserts flush after the stall ends.
- **flush:** bubble carrying the current PC: d_pc=f_pc, d_instr=0, d_exccode=0, d_bd=0, d_valid=0.
- **load with f_ex_adel=1:** d_pc=f_pc, d_instr=0, d_exccode=4, d_bd=f_bd, d_valid=1. The faulting slot must reach CP0 with its PC and bd so the EPC is correct.
- **load, normal:** d_pc=f_pc, d_instr=f_instr, d_exccode=0, d_bd=f_bd, d_valid=1.
- The block never computes PCs; f_pc is taken verbatim. It never decodes instructions.

## Timing
- All outputs are registered. Latency is one cycle from f_* to d_*. There are no combinational input-to-output paths.
- All outputs take their reset values on the first edge with reset=1, whatever the other inputs are. Reset asserted mid-stall clears the state, and the stall is not remembered.
- Back-to-back stalls hold indefinitely. On the first cycle after stall deasserts, the register loads whatever f_* presents.
- req and stall in the same cycle: req wins, and the stall is lost for this register.
- flush and f_ex_adel in the same cycle: flush wins, and no exception is recorded.

## Configuration
- FD_PERF_EN defined: adds ports d_stall_cnt and d_bubble_cnt.
  - d_stall_cnt increments on each edge with stall=1 and no reset/req.
  - d_bubble_cnt increments on each edge that writes a bubble (req or flush).
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- FD_PERF_EN undefined: the counter ports and logic are absent, and the rest of the behaviour is identical.

## Structure
- Shared constants package/header: EXC_ADEL=5'd4, EXC_NONE=5'd0, NOP=32'h0, EXC_ENTRY and RESET_PC defaults, and the text/instruction address bounds used by fetch.
- One sub-module, fd_perf_cnt: two saturating counters with increment enables. It is instantiated only under FD_PERF_EN.

## Test plan
- Reset, then f_pc=0x3000, f_instr=0x3C011234 for one edge -> d_pc=0x3000, d_instr=0x3C011234, d_valid=1, d_exccode=0.
- Load f_pc=0x3004, then stall=1 for 3 edges while f_* changes to 0x3008 -> d_pc stays 0x3004 throughout; deassert stall -> d_pc=0x3008 next edge.
- f_pc=0x3002, f_ex_adel=1, f_bd=1 -> d_instr=0, d_exccode=4, d_bd=1, d_valid=1, d_pc=0x3002.
- req=1 together with stall=1 -> d_pc=0x4180, d_instr=0, d_valid=0; with FD_PERF_EN, d_bubble_cnt increments by 1 and d_stall_cnt is unchanged.
- flush=1 with f_pc=0x3010 -> d_pc=0x3010, d_instr=0, d_valid=0; flush=1 with stall=1 -> state held.
- Assert reset for one edge while stall=1 and d_pc=0x3010 -> d_pc=0x3000, d_valid=0, counters=0.
